// File: rtl/imem_loader.sv
// Byte-stream program loader: SYNC, length, then little-endian words written to imem; holds the core in reset until done.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
    parameter int          ADDR_W    = 6,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic [ADDR_W-1:0] wraddr_o,
    output logic [31:0]       wrdata_o,
    output logic              we_o,
    output logic              core_rst_no,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CHK, S_RUN} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_RUN} state_t;
`endif

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wraddr_q, wraddr_d;
    logic [31:0]         wrdata_q, wrdata_d;
    logic                we_q, we_d;
    logic                core_rst_n_q, core_rst_n_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [1:0]          lane_q, lane_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic [ADDR_W:0]     nwords_q, nwords_d;
    logic [23:0]         asm_q, asm_d;
    logic [ADDR_W:0]     len_words;
    logic                byte_acc;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          xor_q, xor_d;
    logic                err_q, err_d;
`endif

    // The strobe cycle is the only stall, so the sender holds its byte across it.
    assign byte_acc = byte_valid_i & ~we_q;

    always_comb begin
        if (byte_i == 8'd0 || 32'(byte_i) > DEPTH) begin
            len_words = (ADDR_W+1)'(DEPTH);
        end else begin
            len_words = (ADDR_W+1)'(byte_i);
        end
    end

    always_comb begin
        state_d      = state_q;
        wraddr_d     = wraddr_q;
        wrdata_d     = wrdata_q;
        we_d         = 1'b0;
        core_rst_n_d = core_rst_n_q;
        busy_d       = busy_q;
        done_d       = done_q;
        lane_d       = lane_q;
        words_d      = words_q;
        nwords_d     = nwords_q;
        asm_d        = asm_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d        = xor_q;
        err_d        = err_q;
`endif
        if (we_q) begin
            words_d = words_q + 1'b1;
            if (words_d == nwords_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_d      = S_CHK;
`else
                state_d      = S_RUN;
                core_rst_n_d = 1'b1;
                done_d       = 1'b1;
                busy_d       = 1'b0;
`endif
            end else begin
                wraddr_d = wraddr_q + 1'b1;
            end
        end else if (byte_acc) begin
            case (state_q)
                S_IDLE, S_RUN: begin
                    if (byte_i == SYNC_BYTE) begin
                        state_d      = S_LEN;
                        busy_d       = 1'b1;
                        done_d       = 1'b0;
                        core_rst_n_d = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        err_d        = 1'b0;
`endif
                    end
                end
                S_LEN: begin
                    nwords_d = len_words;
                    wraddr_d = '0;
                    lane_d   = '0;
                    words_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d    = 8'h00;
`endif
                    state_d  = S_DATA;
                end
                S_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d  = xor_q ^ byte_i;
`endif
                    lane_d = lane_q + 1'b1;
                    if (lane_q == 2'd3) begin
                        wrdata_d = {byte_i, asm_q};
                        we_d     = 1'b1;
                    end else begin
                        asm_d = {byte_i, asm_q[23:8]};
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    busy_d = 1'b0;
                    if (byte_i == xor_q) begin
                        state_d      = S_RUN;
                        core_rst_n_d = 1'b1;
                        done_d       = 1'b1;
                        err_d        = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b0;
                        err_d   = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            wraddr_q     <= '0;
            wrdata_q     <= '0;
            we_q         <= 1'b0;
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            lane_q       <= '0;
            words_q      <= '0;
            nwords_q     <= '0;
            asm_q        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q        <= 8'h00;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            wraddr_q     <= wraddr_d;
            wrdata_q     <= wrdata_d;
            we_q         <= we_d;
            core_rst_n_q <= core_rst_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            lane_q       <= lane_d;
            words_q      <= words_d;
            nwords_q     <= nwords_d;
            asm_q        <= asm_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q        <= xor_d;
            err_q        <= err_d;
`endif
        end
    end

    assign byte_ready_o = ~we_q;
    assign wraddr_o     = wraddr_q;
    assign wrdata_o     = wrdata_q;
    assign we_o         = we_q;
    assign core_rst_no  = core_rst_n_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign err_o        = err_q;
`else
    assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes, a negedge monitor pops and compares them.
module tb_imem_loader;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    byte_i;
    logic          byte_valid_i;
    logic          byte_ready_o;
    logic [AW-1:0] wraddr_o;
    logic [31:0]   wrdata_o;
    logic          we_o;
    logic          core_rst_no;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    imem_loader #(.ADDR_W(AW), .SYNC_BYTE(8'hA5)) dut (
        .clk_i(clk), .rst_i(rst), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
        .byte_ready_o(byte_ready_o), .wraddr_o(wraddr_o), .wrdata_o(wrdata_o),
        .we_o(we_o), .core_rst_no(core_rst_no), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks   = 0;
    int  failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [31:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_q.push_back(w);
    endtask

    // Valid stays high between sends, so streams run back-to-back across strobes.
    task automatic send(input logic [7:0] b);
        int n = 0;
        byte_i       = b;
        byte_valid_i = 1'b1;
        while (!byte_ready_o && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        if (!byte_ready_o) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: byte_ready_o=%b expected 1 within 8 cycles", byte_ready_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        byte_valid_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drained(input string name);
        idle(3);
        chk(name, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("ready_low_only_in_strobe", byte_ready_o, !we_o);
            if (we_o) begin
                chk("core_held_during_write", core_rst_no, 1'b0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: addr=%0d data=%h expected no write", wraddr_o, wrdata_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", wraddr_o, mon_e.a);
                    chk("wr_data", wrdata_o, mon_e.d);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; byte_valid_i = 1'b0; byte_i = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wraddr", wraddr_o, 0);
        chk("rst_wrdata", wrdata_o, 0);
        chk("rst_we", we_o, 0);
        chk("rst_core_rst_n", core_rst_no, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_ready", byte_ready_o, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Two-word program
        send(8'hA5);
        chk("t1_busy", busy_o, 1);
        chk("t1_core_held", core_rst_no, 0);
        push(0, 32'h00100513);
        push(1, 32'h00200593);
        send(8'h02);
        send(8'h13); send(8'h05); send(8'h10); send(8'h00);
        send(8'h93); send(8'h05); send(8'h20); send(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'hB0);
`endif
        drained("t1_all_writes_seen");
        chk("t1_core_run", core_rst_no, 1);
        chk("t1_done", done_o, 1);
        chk("t1_busy_clear", busy_o, 0);
        chk("t1_err", err_o, 0);

        // Garbage in RUN ignored, then reload of one word
        send(8'h00); send(8'hFF);
        idle(1);
        chk("t2_garbage_done_kept", done_o, 1);
        chk("t2_garbage_core_kept", core_rst_no, 1);
        send(8'hA5);
        chk("t2_restart_done", done_o, 0);
        chk("t2_restart_core", core_rst_no, 0);
        chk("t2_restart_busy", busy_o, 1);
        push(0, 32'h04030201);
        send(8'h01);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h04);
`endif
        drained("t2_all_writes_seen");
        chk("t2_done", done_o, 1);
        chk("t2_core_run", core_rst_no, 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum mismatch leaves core held and flags error
        push(0, 32'h04030201);
        send(8'hA5); send(8'h01);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h05);
        drained("t3_all_writes_seen");
        chk("t3_err", err_o, 1);
        chk("t3_core_held", core_rst_no, 0);
        chk("t3_done", done_o, 0);
        chk("t3_busy", busy_o, 0);
`endif

        // Full-depth frame
        send(8'hA5);
        chk("t4_err_cleared", err_o, 0);
        send(8'h00);
        for (int i = 0; i < 64; i++)
            push(AW'(i), {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
        for (int j = 0; j < 256; j++)
            send(8'(j));
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h00);
`endif
        drained("t4_all_writes_seen");
        chk("t4_core_run", core_rst_no, 1);
        chk("t4_done", done_o, 1);

        // Reset mid-frame after five data bytes
        send(8'hA5); send(8'h02);
        push(0, 32'h44332211);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
        byte_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("t5_first_word_seen", exp_q.size(), 0);
        chk("t5_rst_wraddr", wraddr_o, 0);
        chk("t5_rst_wrdata", wrdata_o, 0);
        chk("t5_rst_we", we_o, 0);
        chk("t5_rst_core", core_rst_no, 0);
        chk("t5_rst_busy", busy_o, 0);
        chk("t5_rst_done", done_o, 0);
        chk("t5_rst_ready", byte_ready_o, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(8'h00); send(8'hFF);
        idle(1);
        chk("t5_idle_garbage_busy", busy_o, 0);
        chk("t5_idle_garbage_core", core_rst_no, 0);
        push(0, 32'hDDCCBBAA);
        send(8'hA5); send(8'h01);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h00);
`endif
        drained("t5_all_writes_seen");
        chk("t5_core_run", core_rst_no, 1);
        chk("t5_done", done_o, 1);

        // Continuous valid across strobes with one gap mid-word
        push(0, 32'h04030201);
        push(1, 32'h08070605);
        send(8'hA5); send(8'h02);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05);
        idle(3);
        chk("t6_gap_busy", busy_o, 1);
        send(8'h06); send(8'h07); send(8'h08);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h08);
`endif
        drained("t6_all_writes_seen");
        chk("t6_core_run", core_rst_no, 1);
        chk("t6_done", done_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader: the writer side of the core's instruction memory, which the core only reads.
- Accepts a framed byte stream (from a UART receiver or test host), assembles little-endian 32-bit instructions and writes them to sequential word addresses.
- Holds the core in reset during loading; releases it once the frame completes.
- Sits between the host link and the instruction-memory write port, beside the core.

Parameters:
- ADDR_W, 6, instruction-memory word-address width; depth = 2**ADDR_W words.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk_i  input  1  system clock, all logic on rising edge.
- rst_i  input  1  asynchronous active-high reset.
- byte_i  input  8  incoming stream byte.
- byte_valid_i  input  1  byte_i valid this cycle; the byte is accepted when byte_valid_i & byte_ready_o.
- byte_ready_o  output  1  loader can accept a byte.
- wraddr_o  output  ADDR_W  instruction-memory word write address.
- wrdata_o  output  32  instruction word to write.
- we_o  output  1  one-cycle write strobe.
- core_rst_no  output  1  active-low reset to the core; 0 holds the core.
- busy_o  output  1  frame in progress.
- done_o  output  1  last frame loaded successfully.
- err_o  output  1  last frame failed checksum; 0 when CHECKSUM_EN is undefined.

Behaviour:
- Reset values (asynchronous on rst_i=1):
  - state=IDLE.
  - wraddr_o=0, wrdata_o=0, we_o=0.
  - core_rst_no=0, busy_o=0, done_o=0, err_o=0.
  - byte_ready_o=1, byte counter=0, word counter=0.
- States: IDLE, LEN, DATA, CHK (macro only), RUN.
- IDLE:
  - Bytes other than SYNC_BYTE are discarded.
  - SYNC_BYTE -> LEN; busy_o=1.
- LEN:
  - Next byte is N, the word count.
  - N=0 or N>2**ADDR_W means 2**ADDR_W words.
  - Clear wraddr_o to 0 and the byte lane index to 0 -> DATA.
- DATA:
  - Bytes fill lanes [7:0], [15:8], [23:16], [31:24] in arrival order.
  - On acceptance of lane 3: register the word into wrdata_o and pulse we_o for exactly one cycle, in the cycle after that byte's acceptance edge.
  - wraddr_o holds the write address during the strobe and increments in the cycle after the strobe.
  - After the Nth word strobe: go to CHK if CHECKSUM_EN is defined, else RUN.
- RUN:
  - core_rst_no=1, done_o=1, busy_o=0.
  - Stray bytes are ignored except SYNC_BYTE.
  - SYNC_BYTE restarts loading: core_rst_no=0 and done_o=0 in the cycle after acceptance -> LEN.
- core_rst_no is 0 in every state except RUN.
- Idle cycles (byte_valid_i=0) inside a frame do not advance state; the loader has no timeout.
- byte_ready_o is 1 in all states except the strobe cycle, where it is 0.
  - One byte is accepted per ready cycle.
  - Bytes offered during the strobe are held by the sender, not lost.
- Reset mid-frame aborts the load. Partially written words remain in memory. core_rst_no stays 0 until a complete frame is loaded.
- Address wrap: the word counter is ADDR_W+1 bits, so the full-depth frame terminates correctly and wraddr_o never exceeds 2**ADDR_W-1.
- Raising rst_i in the same cycle as a byte acceptance: reset wins.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - Running XOR of all DATA bytes, cleared in LEN.
  - CHK state accepts one byte and compares it with the running XOR.
  - Match -> RUN, err_o=0.
  - Mismatch -> IDLE, err_o=1, done_o=0, core_rst_no stays 0.
  - err_o clears on the next SYNC_BYTE.
- Not defined:
  - No CHK state; no checksum byte is expected.
  - err_o is constant 0.

Test Plan:
- Reset then stream A5,02,13,05,10,00,93,05,20,00:
  - we_o pulses twice: addr0=32'h00100513, addr1=32'h00200593.
  - core_rst_no rises after the second strobe (without macro).
- Stream 00,FF,A5 then N=01 and bytes 01,02,03,04:
  - Leading garbage is ignored.
  - Single write addr0=32'h04030201.
  - done_o=1.
- Full-depth frame A5,00 followed by 256 bytes:
  - 64 strobes, addresses 0..63, no write at a 65th address.
  - core_rst_no=1 after the last strobe.
- Assert rst_i after 5 data bytes of an N=2 frame:
  - All outputs return to reset values; core_rst_no=0.
  - A new complete frame then loads from addr0.
- With the macro, frame A5,01,01,02,03,04,04:
  - XOR=04, so the checksum matches: done_o=1, err_o=0.
  - Repeating the frame with a final byte 05: err_o=1, core_rst_no=0.
- Hold byte_valid_i=1 continuously across a strobe cycle:
  - No byte dropped or duplicated; byte_ready_o=0 only in the strobe cycle.
